// File: rtl/mnist_test_sequencer.sv
// Self-test sequencer for the LGN MNIST core: streams each ROM image into the
// core one byte per cycle, samples the predicted class after a fixed latency,
// checks it against the label (image number mod 10) and keeps run statistics.
module mnist_test_sequencer #(
  parameter int IMAGE_COUNT     = 450,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int RESULT_LATENCY  = 2,
  parameter int ADDR_W          = 14,
  parameter int CNT_W           = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_on_fail,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        core_data,
  output logic              core_valid,
  input  logic [3:0]        core_index,
  input  logic [7:0]        core_value,
  output logic              result_valid,
  output logic [3:0]        result_index,
  output logic [7:0]        result_value,
  output logic [3:0]        expected,
  output logic [CNT_W-1:0]  image_num,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              failed,
  output logic              busy,
  output logic              done
);

  localparam int BYTE_W = (BYTES_PER_IMAGE > 1) ? $clog2(BYTES_PER_IMAGE) : 1;
  localparam int LAT_W  = $clog2(RESULT_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    CHECK,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [BYTE_W-1:0] byte_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              vld_p0;
  logic              vld_p1;
  logic              start_run;
  logic              match;
  logic              last_byte;
  logic              last_image;
  logic              lat_done;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Labels cycle 0..9 alongside the image number.
  function automatic logic [3:0] next_label(input logic [3:0] l);
    return (l == 4'd9) ? 4'd0 : l + 4'd1;
  endfunction

  assign vld_p0     = (state_q == STREAM);
  assign start_run  = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign match      = (core_index == expected);
  assign last_byte  = (byte_cnt == BYTE_W'(BYTES_PER_IMAGE - 1));
  assign last_image = (image_num == CNT_W'(IMAGE_COUNT - 1));
  assign lat_done   = (lat_cnt == LAT_W'(RESULT_LATENCY));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and status flags.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (last_byte) state_d = DRAIN;
      DRAIN:   if (lat_done) state_d = CHECK;
      CHECK: begin
        if ((!match && stop_on_fail) || last_image) state_d = DONE;
        else                                         state_d = STREAM;
      end
      DONE:    if (start) state_d = STREAM;
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE) && (state_q != DONE);
    done = (state_q == DONE);
  end

  // Address generation and byte/latency counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      byte_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      if (start_run)                mem_addr <= '0;
      else if (state_q == STREAM)   mem_addr <= mem_addr + ADDR_W'(1);
      byte_cnt <= (state_q == STREAM && !last_byte) ? byte_cnt + BYTE_W'(1) : '0;
      lat_cnt  <= (state_q == DRAIN) ? lat_cnt + LAT_W'(1) : '0;
    end
  end

  // p0: address issued -> p1: ROM data valid -> core_data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      core_valid <= 1'b0;
      core_data  <= '0;
    end else begin
      vld_p1     <= vld_p0;
      core_valid <= vld_p1;
      core_data  <= vld_p1 ? mem_data : 8'd0;
    end
  end

  // Result capture, label tracking and pass/fail bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_index <= '0;
      result_value <= '0;
      expected     <= '0;
      image_num    <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      failed       <= 1'b0;
    end else begin
      result_valid <= (state_q == CHECK);
      if (start_run) begin
        expected   <= '0;
        image_num  <= '0;
        pass_count <= '0;
        fail_count <= '0;
        failed     <= 1'b0;
      end else if (state_q == CHECK) begin
        result_index <= core_index;
        result_value <= core_value;
        if (match) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          failed     <= 1'b1;
        end
        if (state_d == STREAM) begin
          image_num <= image_num + CNT_W'(1);
          expected  <= next_label(expected);
        end
      end
    end
  end

endmodule
